// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding
// and the width of one adder step.
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// Shared 4-bit ripple-carry adder cell, built as a chain of full adders.
module rca_using_full_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit ripple-carry cell over WIDTH/4 cycles,
// least-significant nibble first, with a registered carry between steps.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
  logic             nib_cout;
  logic             accept, last;

  assign accept = start && ready;
  assign last   = (idx == IDX_W'(NIB - 1));
  assign nib_a  = a_reg[int'(idx) * NIB_W +: NIB_W];
  assign nib_b  = b_reg[int'(idx) * NIB_W +: NIB_W];

  rca_using_full_adder u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_RUN:  busy  = 1'b1;
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Accept only happens from IDLE/DONE, so it never collides with a RUN step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      idx       <= '0;
      sum       <= '0;
    end else if (state == S_RUN) begin
      sum[int'(idx) * NIB_W +: NIB_W] <= nib_sum;
      carry_reg <= nib_cout;
      if (last) cout <= nib_cout;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed checks of the nibble-serial adder against a
// timing/arithmetic model of the requester-visible behaviour.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int W1    = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             ready, busy, done, cout;
  logic [WIDTH-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Model: the last accepted operation, when it was accepted, and its true sum.
  bit          have_op = 1'b0;
  bit          m_ready;
  longint      cyc = 0;
  longint      t_acc = 0;
  longint      el;
  logic [W1-1:0] op_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have_op = 1'b0;
    end else begin
      m_ready = !have_op || ((cyc - t_acc) >= NIB);
      cyc++;
      if (m_ready && start) begin
        t_acc   = cyc;
        have_op = 1'b1;
        op_res  = {1'b0, a} + {1'b0, b} + W1'(cin);
      end
    end
  end

  logic          er, eb, ed, chk;
  logic [W1-1:0] es;

  always @(negedge clk) begin
    if (rst || !have_op) begin
      er = 1'b1; eb = 1'b0; ed = 1'b0; chk = 1'b1; es = '0;
    end else begin
      el  = cyc - t_acc;
      eb  = (el < NIB);
      er  = !eb;
      ed  = (el == NIB);
      chk = !eb;
      es  = op_res;
    end
    vectors++;
    if ({ready, busy, done} !== {er, eb, ed}) begin
      miscompares++;
      $display("FAIL ctrl t=%0t ready/busy/done got %b%b%b want %b%b%b",
               $time, ready, busy, done, er, eb, ed);
    end
    if (chk) begin
      vectors++;
      if ({cout, sum} !== es) begin
        miscompares++;
        $display("FAIL result t=%0t cout/sum got %b/%h want %b/%h",
                 $time, cout, sum, es[WIDTH], es[WIDTH-1:0]);
      end
    end
  end

  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input logic [W1-1:0] exp, input int lat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    vectors++;
    if (!done || n != lat || {cout, sum} !== exp) begin
      miscompares++;
      $display("FAIL %s done=%b latency got %0d want %0d cout/sum got %b/%h want %b/%h",
               name, done, n, lat, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({ready, busy, done, cout, sum} !== {3'b100, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_state got r%b b%b d%b c%b s%h want r1 b0 d0 c0 s0000",
               ready, busy, done, cout, sum);
    end

    launch(16'h1234, 16'h4321, 1'b0);
    wait_done({1'b0, 16'h5555}, 5, "add_1234_4321");
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done({1'b1, 16'h0000}, 5, "ripple_ffff_0001");
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done({1'b1, 16'hFFFF}, 5, "max_with_cin");
    launch(16'h0000, 16'h0000, 1'b1);
    wait_done({1'b0, 16'h0001}, 5, "cin_only");

    launch(16'h00F0, 16'h0010, 1'b0);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b0; a = 16'h1357; b = 16'h2468;
    wait_done({1'b0, 16'h0100}, 3, "start_during_run_ignored");
    repeat (3) @(posedge clk);
    #1;

    launch(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ready, busy, done, cout, sum} !== {3'b100, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL async_reset_midrun got r%b b%b d%b c%b s%h want r1 b0 d0 c0 s0000",
               ready, busy, done, cout, sum);
    end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    launch(16'h8000, 16'h8000, 1'b0);
    wait_done({1'b1, 16'h0000}, 5, "after_reset_8000_8000");

    launch(16'h1111, 16'h2222, 1'b0);
    wait_done({1'b0, 16'h3333}, 5, "b2b_first");
    launch(16'h0F0F, 16'h0101, 1'b0);
    wait_done({1'b0, 16'h1010}, 5, "b2b_second");

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a     = ($urandom_range(0, 5) == 0) ? 16'hFFFF : WIDTH'($urandom);
      b     = ($urandom_range(0, 5) == 0) ? 16'h0001 : WIDTH'($urandom);
      cin   = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
